// File: rtl/rv32i_multiplier_arbiter.sv
// -----------------------------------------------------------------------------
// rv32i_multiplier_arbiter
//
// Shares one 16x16 multiplier IP between NUM_REQ execute-stage requesters.
// Each requester holds i_req_en (level) with its operands until it receives a
// one-cycle o_req_valid strobe. Grants rotate round-robin starting after the
// last served requester, and exactly one IP transaction is in flight at a time.
//
// Optional feature macro: RV32I_MULTIPLIER_ARB_TIMEOUT_EN
//   When defined, adds o_req_timeout and a busy-cycle counter. If the IP gives
//   no valid within TIMEOUT_CYCLES busy cycles, the granted requester receives
//   a zero result together with a one-cycle o_req_timeout strobe.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_en[NUM_REQ]             per-requester request level
//   i_req_operand_one/two         packed 16-bit operands, requester k at [16k+:16]
//   o_req_valid[NUM_REQ]          one-hot, one-cycle result strobe
//   o_req_result[32]              product returned with the strobe
//   o_grant_id                    current or last granted requester
//   o_busy                        IP transaction in flight
//   o_req_timeout                 (macro only) timeout flag with the strobe
//   o_multiplier_en/operand_*     IP request side
//   i_multiplier_valid/result     IP response side
// -----------------------------------------------------------------------------
module rv32i_multiplier_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_REQ-1:0]                   i_req_en,
   input  logic [16*NUM_REQ-1:0]                i_req_operand_one,
   input  logic [16*NUM_REQ-1:0]                i_req_operand_two,
   output logic [NUM_REQ-1:0]                   o_req_valid,
   output logic [31:0]                          o_req_result,
   output logic [$clog2(NUM_REQ)-1:0]           o_grant_id,
   output logic                                 o_busy,
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
   output logic                                 o_req_timeout,
`endif
   output logic                                 o_multiplier_en,
   output logic [15:0]                          o_multiplier_operand_one,
   output logic [15:0]                          o_multiplier_operand_two,
   input  logic                                 i_multiplier_valid,
   input  logic [31:0]                          i_multiplier_result
);

   localparam int GW = $clog2(NUM_REQ);

   // Elaboration-time parameter sanity checks.
   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("NUM_REQ must be in 2..4");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {ArbIdle, ArbBusy, ArbRespond} arb_state_t;

   arb_state_t           state_reg, state_next;
   logic [GW-1:0]        last_grant_reg, last_grant_next;
   logic [GW-1:0]        grant_reg, grant_next;
   logic                 mul_en_reg, mul_en_next;
   logic [15:0]          op_one_reg, op_one_next;
   logic [15:0]          op_two_reg, op_two_next;
   logic [NUM_REQ-1:0]   req_valid_reg, req_valid_next;
   logic [31:0]          result_reg, result_next;
   logic                 busy_reg, busy_next;
   // Sticky: the granted requester let go of en at some point during ArbBusy.
   logic                 abandon_reg, abandon_next;

`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;
   logic                 timeout_reg, timeout_next;
   logic                 tmo_hit;
   assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`endif

   // Round-robin candidates in priority order: cand_idx[0] is last_grant+1.
   logic [GW-1:0]        cand_idx [NUM_REQ];
   logic [GW-1:0]        sel_idx;
   logic                 any_req;
   logic                 live_grant;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [31:0] rot_sum;
         assign rot_sum      = 32'(last_grant_reg) + 32'(gi + 1);
         assign cand_idx[gi] = GW'(rot_sum % 32'(NUM_REQ));
      end
   endgenerate

   // Walk from lowest to highest priority so the highest-priority hit wins.
   always_comb begin
      sel_idx = cand_idx[0];
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_en[cand_idx[i]]) begin
            sel_idx = cand_idx[i];
         end
      end
   end

   assign any_req    = |i_req_en;
   assign live_grant = ~abandon_reg & i_req_en[grant_reg];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg      <= ArbIdle;
         last_grant_reg <= GW'(NUM_REQ - 1);
         grant_reg      <= '0;
         mul_en_reg     <= 1'b0;
         op_one_reg     <= '0;
         op_two_reg     <= '0;
         req_valid_reg  <= '0;
         result_reg     <= '0;
         busy_reg       <= 1'b0;
         abandon_reg    <= 1'b0;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
         timeout_reg    <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         grant_reg      <= grant_next;
         mul_en_reg     <= mul_en_next;
         op_one_reg     <= op_one_next;
         op_two_reg     <= op_two_next;
         req_valid_reg  <= req_valid_next;
         result_reg     <= result_next;
         busy_reg       <= busy_next;
         abandon_reg    <= abandon_next;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
         tmo_cnt_reg    <= tmo_cnt_next;
         timeout_reg    <= timeout_next;
`endif
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      grant_next      = grant_reg;
      mul_en_next     = mul_en_reg;
      op_one_next     = op_one_reg;
      op_two_next     = op_two_reg;
      req_valid_next  = '0;            // strobe only ever lasts one cycle
      result_next     = result_reg;
      busy_next       = busy_reg;
      abandon_next    = abandon_reg;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
      tmo_cnt_next    = tmo_cnt_reg;
      timeout_next    = 1'b0;
`endif
      case (state_reg)
         ArbIdle: begin
            if (any_req) begin
               grant_next   = sel_idx;
               op_one_next  = i_req_operand_one[16*sel_idx +: 16];
               op_two_next  = i_req_operand_two[16*sel_idx +: 16];
               mul_en_next  = 1'b1;
               busy_next    = 1'b1;
               abandon_next = 1'b0;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
               tmo_cnt_next = '0;
`endif
               state_next   = ArbBusy;
            end
         end
         ArbBusy: begin
            abandon_next = abandon_reg | ~i_req_en[grant_reg];
            if (i_multiplier_valid) begin
               mul_en_next     = 1'b0;
               last_grant_next = grant_reg;
               state_next      = ArbRespond;
               // An abandoned transaction completes silently.
               if (live_grant) begin
                  req_valid_next[grant_reg] = 1'b1;
                  result_next               = i_multiplier_result;
               end
            end
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               mul_en_next               = 1'b0;
               last_grant_next           = grant_reg;
               req_valid_next[grant_reg] = 1'b1;
               result_next               = '0;
               timeout_next              = 1'b1;
               state_next                = ArbRespond;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
`endif
         end
         ArbRespond: begin
            busy_next  = 1'b0;
            state_next = ArbIdle;
         end
         default: begin
            state_next = ArbIdle;
         end
      endcase
   end

   assign o_req_valid              = req_valid_reg;
   assign o_req_result             = result_reg;
   assign o_grant_id               = grant_reg;
   assign o_busy                   = busy_reg;
   assign o_multiplier_en          = mul_en_reg;
   assign o_multiplier_operand_one = op_one_reg;
   assign o_multiplier_operand_two = op_two_reg;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
   assign o_req_timeout            = timeout_reg;
`endif

endmodule

// File: tb/tb_rv32i_multiplier_arbiter.sv
module tb_rv32i_multiplier_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_en;
   logic [31:0] req_op_one;
   logic [31:0] req_op_two;
   logic [1:0]  req_valid;
   logic [31:0] req_result;
   logic [0:0]  grant_id;
   logic        busy;
   logic        mul_en;
   logic [15:0] mul_op_one;
   logic [15:0] mul_op_two;
   logic        ip_valid;
   logic [31:0] ip_result;
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
   logic        req_timeout;
`endif

   always #5 clk = ~clk;

   rv32i_multiplier_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_req_en                 (req_en),
      .i_req_operand_one        (req_op_one),
      .i_req_operand_two        (req_op_two),
      .o_req_valid              (req_valid),
      .o_req_result             (req_result),
      .o_grant_id               (grant_id),
      .o_busy                   (busy),
`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
      .o_req_timeout            (req_timeout),
`endif
      .o_multiplier_en          (mul_en),
      .o_multiplier_operand_one (mul_op_one),
      .o_multiplier_operand_two (mul_op_two),
      .i_multiplier_valid       (ip_valid),
      .i_multiplier_result      (ip_result)
   );

   // ---------------- multiplier IP model ----------------
   int          ip_lat = 2;
   logic        ip_enable = 1'b1;
   logic        ip_force = 1'b0;
   logic [31:0] ip_force_val = '0;
   logic        ip_pulse = 1'b0;
   int          ip_cnt = 0;
   logic        ip_done = 1'b0;

   initial begin
      ip_valid  = 1'b0;
      ip_result = '0;
   end

   always @(posedge clk) begin
      ip_valid <= 1'b0;
      if (ip_pulse) begin
         ip_valid  <= 1'b1;
         ip_result <= 32'hBAD0_0BAD;
      end else if (!mul_en) begin
         ip_cnt  <= 0;
         ip_done <= 1'b0;
      end else if (ip_enable && !ip_done) begin
         if (ip_cnt == ip_lat - 1) begin
            ip_valid  <= 1'b1;
            ip_result <= ip_force ? ip_force_val : (32'(mul_op_one) * 32'(mul_op_two));
            ip_done   <= 1'b1;
         end else begin
            ip_cnt <= ip_cnt + 1;
         end
      end
   end

   // ---------------- scoreboard / checking ----------------
   typedef struct {
      logic [1:0]  valid;
      logic [31:0] result;
      logic [0:0]  gid;
   } exp_t;

   typedef struct {
      logic [1:0]  en;
      logic [15:0] a0, b0, a1, b1;
      int          lat;
      int          win;
   } vec_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", name, act);
      end
   endtask

   task automatic push_exp(input int who, input logic [31:0] res);
      exp_t e;
      e.valid  = 2'b01 << who;
      e.result = res;
      e.gid    = 1'(who);
      sb.push_back(e);
   endtask

   // One clock; sample #1 after the edge and check any result strobe.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (req_valid != 2'b00) begin
         seen = 1'b1;
         chk("valid_onehot", 32'($countones(req_valid)), 32'd1);
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got valid %b expected none", req_valid);
         end else begin
            e = sb.pop_front();
            chk("strobe_valid", 32'(req_valid), 32'(e.valid));
            chk("strobe_result", req_result, e.result);
            chk("strobe_grant", 32'(grant_id), 32'(e.gid));
         end
      end
   endtask

   task automatic wait_strobe(input string name, input int budget);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) tick();
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s: got no strobe expected one within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_mul_en(input string name, input logic level);
      int n = 0;
      while (mul_en !== level && n < 20) begin
         tick();
         n++;
      end
      if (mul_en !== level) begin
         tests++;
         fails++;
         $display("FAIL %s: got mul_en %b expected %b", name, mul_en, level);
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
      chk({tag, "_req_result"}, req_result, 32'd0);
      chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mul_en"}, 32'(mul_en), 32'd0);
      chk({tag, "_op_one"}, 32'(mul_op_one), 32'd0);
      chk({tag, "_op_two"}, 32'(mul_op_two), 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      logic [15:0] a, b;
      int n;
      // {en to raise, a0, b0, a1, b1, ip latency, expected winner}
      vecs[0] = '{2'b01, 16'h0003, 16'h0010, 16'h0000, 16'h0000, 2, 0};
      vecs[1] = '{2'b11, 16'h0005, 16'h0007, 16'h0011, 16'h0003, 1, 1};
      vecs[2] = '{2'b10, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0002, 3, 0};
      vecs[3] = '{2'b01, 16'h0100, 16'h0100, 16'h8000, 16'h0002, 2, 1};
      vecs[4] = '{2'b10, 16'h1234, 16'h5678, 16'h0009, 16'h0009, 4, 0};
      vecs[5] = '{2'b00, 16'h0000, 16'h0000, 16'hABCD, 16'h0001, 5, 1};
      vecs[6] = '{2'b10, 16'h0000, 16'h0000, 16'h00FF, 16'h0101, 1, 1};

      rst = 1'b1;
      req_en = '0;
      req_op_one = '0;
      req_op_two = '0;
      repeat (3) tick();
      check_cleared("reset");
      rst = 1'b0;

      // Table-driven transactions: single request, then alternating contention.
      for (int r = 0; r < 7; r++) begin
         req_op_one = {vecs[r].a1, vecs[r].a0};
         req_op_two = {vecs[r].b1, vecs[r].b0};
         ip_lat     = vecs[r].lat;
         req_en     = req_en | vecs[r].en;
         a = vecs[r].win == 1 ? vecs[r].a1 : vecs[r].a0;
         b = vecs[r].win == 1 ? vecs[r].b1 : vecs[r].b0;
         push_exp(vecs[r].win, 32'(a) * 32'(b));
         if (r == 0) begin
            wait_mul_en("row0_en", 1'b1);
            chk("row0_ip_op_one", 32'(mul_op_one), 32'h0003);
            chk("row0_ip_op_two", 32'(mul_op_two), 32'h0010);
         end
         wait_strobe($sformatf("row%0d_strobe", r), 40);
         req_en[vecs[r].win] = 1'b0;
         tick();
         chk($sformatf("row%0d_busy_after", r), 32'(busy), 32'd0);
      end

      // Operand stability: requester 1 changes operand A while in ArbBusy.
      ip_lat = 6;
      req_op_one = {16'h1234, 16'h0000};
      req_op_two = {16'h0002, 16'h0000};
      req_en = 2'b10;
      push_exp(1, 32'h0000_2468);
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (mul_en) begin
            chk("stable_op_one", 32'(mul_op_one), 32'h1234);
            req_op_one = {16'hFFFF, 16'h0000};
            n++;
         end
      end
      if (!seen || n == 0) begin
         tests++;
         fails++;
         $display("FAIL stable_strobe: got seen=%0d en_cycles=%0d expected strobe", seen, n);
      end
      req_en = 2'b00;
      tick();

      // Abandon: requester 0 drops en one cycle after grant; its result is dropped.
      ip_lat = 3;
      ip_force = 1'b1;
      ip_force_val = 32'h0000_DEAD;
      req_op_one = {16'h0007, 16'h0001};
      req_op_two = {16'h0009, 16'h0001};
      req_en = 2'b01;
      wait_mul_en("abandon_en", 1'b1);
      chk("abandon_grant", 32'(grant_id), 32'd0);
      tick();
      req_en = 2'b10;
      push_exp(1, 32'd63);
      n = 0;
      while (busy && n < 30) begin
         tick();
         n++;
      end
      chk("abandon_busy_clear", 32'(busy), 32'd0);
      ip_force = 1'b0;
      wait_strobe("abandon_next_req1", 40);
      req_en = 2'b00;
      tick();

      // Reset mid-transaction: serve req0 so req1 would otherwise be next.
      ip_lat = 2;
      req_op_one = {16'h0004, 16'h0006};
      req_op_two = {16'h0005, 16'h0007};
      req_en = 2'b01;
      push_exp(0, 32'd42);
      wait_strobe("pre_reset_req0", 40);
      req_en = 2'b00;
      tick();
      ip_enable = 1'b0;
      req_en = 2'b10;
      wait_mul_en("pre_reset_busy", 1'b1);
      rst = 1'b1;
      req_en = 2'b00;
      tick();
      tick();
      check_cleared("midrst");
      rst = 1'b0;
      ip_pulse = 1'b1;
      tick();
      ip_pulse = 1'b0;
      tick();
      chk("spurious_valid_ignored", 32'(req_valid), 32'd0);
      chk("spurious_busy", 32'(busy), 32'd0);
      ip_enable = 1'b1;
      req_en = 2'b11;
      push_exp(0, 32'd42);
      wait_strobe("post_reset_req0", 40);
      req_en = 2'b10;
      push_exp(1, 32'd20);
      wait_strobe("post_reset_req1", 40);
      req_en = 2'b00;
      tick();

`ifdef RV32I_MULTIPLIER_ARB_TIMEOUT_EN
      // Timeout: IP never answers; req0 gets a zero result and a timeout flag.
      ip_enable = 1'b0;
      req_en = 2'b01;
      push_exp(0, 32'd0);
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (mul_en) n++;
      end
      chk("timeout_seen", 32'(seen), 32'd1);
      chk("timeout_flag", 32'(req_timeout), 32'd1);
      chk("timeout_en_cycles", 32'(n), 32'd8);
      req_en = 2'b00;
      tick();
      chk("timeout_flag_clear", 32'(req_timeout), 32'd0);
      ip_enable = 1'b1;
`endif

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rv32i_multiplier_arbiter.md
Name: rv32I_multiplier_arbiter

Overview:
- Shares the single 16x16 multiplier IP between several execute-stage requesters, for example the shift control path and the MUL/MULH sequencer.
- Each requester keeps the same en/valid handshake it would use with the IP directly.
- The arbiter grants round-robin, holds the IP for one transaction at a time, and routes the 32-bit product back to the granted requester only.
- Sits between the instruction_execute control paths and the multiplier IP instance.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- TIMEOUT_CYCLES, 64: max cycles to wait for IP valid. Used only with the optional feature.

Ports:
- i_clk  input  1  core clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_req_en  input  NUM_REQ  per-requester multiply request (level, held until served).
- i_req_operand_one  input  16*NUM_REQ  operand A; requester k uses bits [16k+15:16k].
- i_req_operand_two  input  16*NUM_REQ  operand B; same packing as operand A.
- o_req_valid  output  NUM_REQ  one-cycle result strobe, one-hot.
- o_req_result  output  32  product, meaningful when any o_req_valid bit is high.
- o_grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- o_busy  output  1  IP transaction in flight.
- o_multiplier_en  output  1  IP request.
- o_multiplier_operand_one  output  16  IP operand A.
- o_multiplier_operand_two  output  16  IP operand B.
- i_multiplier_valid  input  1  IP result strobe.
- i_multiplier_result  input  32  IP product.

Behaviour:
- Reset (synchronous, active-high), applies on any cycle including mid-transaction:
  - state=ArbIdle; o_multiplier_en=0; operands=0; o_req_valid=0; o_req_result=0; o_grant_id=0; o_busy=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - An in-flight IP result arriving after reset is ignored.
- All outputs are registered.
- FSM states: ArbIdle, ArbBusy, ArbRespond.
- ArbIdle:
  - If any i_req_en bit is set, select the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - Latch that requester's operands into o_multiplier_operand_one/two.
  - Set o_grant_id; set o_multiplier_en=1 and o_busy=1 on the next edge; go to ArbBusy.
  - With no request, stay in ArbIdle.
- ArbBusy:
  - Hold o_multiplier_en=1 and operands stable. Operands are latched at grant; later changes on i_req_operand_* are ignored.
  - On i_multiplier_valid: capture i_multiplier_result into o_req_result; set o_req_valid[grant]=1; set o_multiplier_en=0; set last_grant=grant; go to ArbRespond.
  - If the granted requester drops i_req_en while in ArbBusy, the transaction still runs to IP valid. The result is then discarded: o_req_valid stays 0 and the FSM goes to ArbRespond with no strobe.
- ArbRespond:
  - Lasts exactly 1 cycle. o_req_valid is high for this cycle only, then clears.
  - Requests are not sampled here. A served requester may still hold en high during this cycle and must drop it by the next cycle.
  - Next state is ArbIdle; o_busy=0 on entering ArbIdle.
- Latency: grant edge to o_multiplier_en high is 1 cycle. IP valid to o_req_valid high is 1 cycle. Minimum back-to-back issue spacing is 3 cycles plus IP latency.
- Fairness:
  - A requester cannot win twice in a row while another requester is pending.
  - Simultaneous requests are resolved purely by the round-robin pointer.
- Spurious i_multiplier_valid in ArbIdle or ArbRespond is ignored.
- o_req_valid is never multi-hot.

Optional Feature:
- Macro: RV32I_MULTIPLIER_ARB_TIMEOUT_EN.
- When defined:
  - Adds output o_req_timeout (1 bit) and a cycle counter.
  - The counter clears on entry to ArbBusy and increments each ArbBusy cycle.
  - On reaching TIMEOUT_CYCLES without i_multiplier_valid: o_multiplier_en=0; o_req_valid[grant]=1; o_req_result=32'h0; o_req_timeout=1 for that one ArbRespond cycle; last_grant updated; go to ArbRespond.
  - If i_multiplier_valid and the timeout hit occur in the same cycle, valid wins and o_req_timeout stays 0.
  - o_req_timeout resets to 0.
- When undefined: no o_req_timeout port and no counter; ArbBusy waits indefinitely for IP valid.

Test Plan:
- Single request: after reset, req0 with A=16'h0003, B=16'h0010; IP returns 32'h30 after 2 cycles -> operands 0003/0010 on IP; o_req_valid=2'b01 for one cycle with o_req_result=32'h00000030; o_busy=0 afterward.
- Contention: req0 and req1 asserted together and held -> grants in order 0,1,0,1; o_grant_id alternates; o_req_valid is never 2'b11.
- Operand stability: req1 changes operand_one from 16'h1234 to 16'hFFFF mid-ArbBusy -> o_multiplier_operand_one stays 16'h1234 until IP valid.
- Abandon: req0 drops en 1 cycle after grant; IP returns 32'hDEAD -> o_req_valid stays 0; next pending req1 is granted after ArbRespond.
- Reset mid-transaction: assert i_rst in ArbBusy, then IP valid arrives 1 cycle after release -> all outputs 0; valid ignored; next grant goes to req0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): IP never responds -> after 8 ArbBusy cycles o_multiplier_en=0; o_req_valid[grant]=1; o_req_result=0; o_req_timeout=1 for 1 cycle.
